// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg : shared FSM state type, register offsets and baud default. Rev 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [15:0] UART_TXDATA          = 16'd0;
  localparam logic [15:0] UART_STATUS          = 16'd1;
  localparam int          CLKS_PER_BIT_DEFAULT = 434;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sync_fifo : first-word-fall-through FIFO with wrap-bit pointers. Rev 1.0
// ----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW  = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q[AW-1:0]];
  assign count   = count_q;

  always_comb begin
    wptr_d  = do_push ? wptr_q + ONE : wptr_q;
    rptr_d  = do_pop  ? rptr_q + ONE : rptr_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_port.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_tx_port : memory-mapped 8N1 UART transmitter with byte FIFO. Rev 1.0
// ----------------------------------------------------------------------------
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        UARTEnable,
  input  logic        MemWrite,
  input  logic [15:0] address_physical,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        uartfull,
  output logic        tx
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;

  logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [AW:0] fifo_count;
  logic        busy, baud_done;
  logic        unused_bits;

  assign fifo_push = UARTEnable && MemWrite && (address_physical == UART_TXDATA);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (write_data[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign uartfull    = (fifo_count == FULL_COUNT);
  assign busy        = (state_q != IDLE) || !fifo_empty;
  assign read_data   = (UARTEnable && (address_physical == UART_STATUS)) ?
                       {30'b0, busy, uartfull} : 32'b0;
  assign tx          = tx_q;
  assign baud_done   = (baud_q == BAUD_LAST);
  assign unused_bits = ^{write_data[31:8], fifo_full};

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;
    tx_d     = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        // tx follows the state one clock later, so the line lags the FSM by one cycle.
        tx_d = shift_q[0];
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_port.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_tx_port : model-checked bench for the UART TX port. Rev 1.0
// ----------------------------------------------------------------------------
module tb_uart_tx_port;

  localparam int C     = 4;
  localparam int D     = 8;
  localparam int FRAME = 10 * C;

  logic        clk              = 1'b0;
  logic        reset            = 1'b1;
  logic        UARTEnable       = 1'b0;
  logic        MemWrite         = 1'b0;
  logic [15:0] address_physical = 16'd0;
  logic [31:0] write_data       = 32'd0;
  logic [31:0] read_data;
  logic        uartfull;
  logic        tx;

  int checks   = 0;
  int failures = 0;

  uart_tx_port #(
    .CLKS_PER_BIT (C),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .UARTEnable       (UARTEnable),
    .MemWrite         (MemWrite),
    .address_physical (address_physical),
    .write_data       (write_data),
    .read_data        (read_data),
    .uartfull         (uartfull),
    .tx               (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the position inside the current frame.
  logic [7:0] mq[$];
  int         fpos      = -1;
  int         prev_fpos = -1;
  logic [7:0] cur_byte  = 8'd0;
  logic [7:0] prev_byte = 8'd0;
  logic       m_push;

  function automatic logic model_tx(input int pos, input logic [7:0] b);
    int k;
    if (pos < 0) return 1'b1;
    k = pos / C;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      mq.delete();
      fpos      = -1;
      prev_fpos = -1;
    end else begin
      m_push    = UARTEnable && MemWrite && (address_physical == 16'd0) && (mq.size() < D);
      prev_fpos = fpos;
      prev_byte = cur_byte;
      if (fpos < 0) begin
        if (mq.size() != 0) begin
          cur_byte = mq.pop_front();
          fpos     = 0;
        end
      end else if (fpos == FRAME - 1) begin
        fpos = -1;
      end else begin
        fpos = fpos + 1;
      end
      if (m_push) mq.push_back(write_data[7:0]);
    end
  end

  initial forever begin
    logic busy_m, full_m;
    @(negedge clk);
    busy_m = (fpos >= 0) || (mq.size() != 0);
    full_m = (mq.size() == D);
    check("tx_model", {31'b0, tx}, {31'b0, model_tx(prev_fpos, prev_byte)});
    check("uartfull_model", {31'b0, uartfull}, {31'b0, full_m});
    check("read_data_model", read_data,
          (UARTEnable && address_physical == 16'd1) ? {30'b0, busy_m, full_m} : 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic en, input logic [15:0] a, input logic [31:0] d);
    UARTEnable       = en;
    MemWrite         = 1'b1;
    address_physical = a;
    write_data       = d;
    tick();
    MemWrite         = 1'b0;
  endtask

  task automatic rx_byte(output logic [7:0] b, output time t_fall, output bit ok);
    ok     = 1'b0;
    b      = 8'd0;
    t_fall = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL rx_timeout: tx stayed %b, required a start bit 0", tx);
      return;
    end
    t_fall = $time;
    repeat (2) @(negedge clk);
    check("rx_start", {31'b0, tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge clk);
      b[i] = tx;
    end
    repeat (C) @(negedge clk);
    check("rx_stop", {31'b0, tx}, 32'd1);
  endtask

  logic [9:0] seq;
  logic [7:0] rb;
  time        tf, tprev;
  bit         ok;

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();
    UARTEnable       = 1'b1;
    address_physical = 16'd1;
    #1;
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_uartfull", {31'b0, uartfull}, 32'd0);
    check("reset_status", read_data, 32'd0);

    // Single byte 0xA5: fall two edges after the push, then the literal line pattern.
    wr(1'b1, 16'd0, 32'hFFFF_FFA5);
    address_physical = 16'd1;
    check("latency_edge_n", {31'b0, tx}, 32'd1);
    tick();
    check("latency_edge_n1", {31'b0, tx}, 32'd1);
    tick();
    check("latency_edge_n2", {31'b0, tx}, 32'd0);
    seq = 10'b1101001010;
    repeat (2) tick();
    for (int j = 0; j < 10; j++) begin
      check("a5_line_bit", {31'b0, tx}, {31'b0, seq[j]});
      if (j == 4) check("status_mid_frame", read_data, 32'h0000_0002);
      repeat (C) tick();
    end
    check("busy_after_stop", read_data, 32'd0);

    // Ignored writes: wrong offset and window not selected.
    wr(1'b1, 16'd5, 32'h5A);
    wr(1'b0, 16'd0, 32'h77);
    UARTEnable       = 1'b1;
    address_physical = 16'd1;
    repeat (45) tick();
    check("ignored_tx", {31'b0, tx}, 32'd1);
    check("ignored_status", read_data, 32'd0);

    // A leading byte keeps the FSM busy so nine writes overflow the eight-entry FIFO.
    fork
      begin
        wr(1'b1, 16'd0, 32'h00);
        for (int k = 1; k <= 9; k++) begin
          wr(1'b1, 16'd0, k);
          if (k == 7) check("not_full_after_7", {31'b0, uartfull}, 32'd0);
          if (k == 8) check("full_after_8", {31'b0, uartfull}, 32'd1);
        end
        UARTEnable       = 1'b1;
        MemWrite         = 1'b1;
        address_physical = 16'd0;
        write_data       = 32'hEE;
        for (int i = 0; i < 100; i++) begin
          tick();
          if (!uartfull) break;
        end
        MemWrite = 1'b0;
        check("full_release_on_pop", {31'b0, uartfull}, 32'd0);
      end
      begin
        tprev = 0;
        for (int f = 0; f < 9; f++) begin
          rx_byte(rb, tf, ok);
          if (!ok) break;
          check("rx_byte", {24'b0, rb}, f);
          if (f >= 1) check("frame_gap", 32'(tf - tprev), 32'd410);
          tprev = tf;
        end
      end
    join
    address_physical = 16'd1;
    repeat (60) tick();
    check("drained_tx", {31'b0, tx}, 32'd1);
    check("drained_status", read_data, 32'd0);

    // Reset in the middle of DATA bit 3 of 0x3C with two bytes still queued.
    wr(1'b1, 16'd0, 32'h3C);
    wr(1'b1, 16'd0, 32'h11);
    wr(1'b1, 16'd0, 32'h22);
    address_physical = 16'd1;
    repeat (16) tick();
    check("bit3_of_3c", {31'b0, tx}, 32'd1);
    check("status_busy_queued", read_data, 32'h0000_0002);
    #2;
    reset = 1'b1;
    #1;
    check("reset_forces_tx", {31'b0, tx}, 32'd1);
    check("reset_status_now", read_data, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (60) tick();
    check("post_reset_tx", {31'b0, tx}, 32'd1);
    check("post_reset_status", read_data, 32'd0);

    // Random traffic with bursty writes and occasional resets.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int r;
      UARTEnable = ($urandom_range(0, 3) != 0);
      if ((cyc % 500) < 100) MemWrite = ($urandom_range(0, 1) == 1);
      else                   MemWrite = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 7);
      if (r < 4)      address_physical = 16'd0;
      else if (r < 6) address_physical = 16'd1;
      else            address_physical = 16'($urandom_range(0, 31));
      write_data = $urandom();
      reset      = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset            = 1'b0;
    MemWrite         = 1'b0;
    UARTEnable       = 1'b1;
    address_physical = 16'd1;
    repeat (500) tick();
    check("final_idle_status", read_data, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
